// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcodes common to alu_control and alu_unit, multiplier FSM states.
package alu_defs;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_MUL = 4'd2,
      OP_AND = 4'd3,
      OP_OR  = 4'd4
   } alu_op_e;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_MUL_RUN = 1'b1
   } mul_state_e;

   // Iteration counter width: ceil(log2(n)) + 1 bits.
   function automatic int cnt_w(input int n);
      return $clog2(n) + 1;
   endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
// done/product are presented combinationally on the final iteration so the caller can register them at that edge.
module alu_mul_seq
   import alu_defs::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     op_a,
   input  logic [WIDTH-1:0]     op_b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int CW = cnt_w(MUL_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(MUL_CYCLES - 1);

   mul_state_e          state;
   logic [CW-1:0]       cnt;
   logic [2*WIDTH-1:0]  mcand_p0;
   logic [2*WIDTH-1:0]  acc_p0;
   logic [2*WIDTH-1:0]  acc_nxt;
   logic [WIDTH-1:0]    mplier_p0;

   always_comb begin
      acc_nxt = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);
   end

   assign busy    = (state == ST_MUL_RUN);
   assign done    = (state == ST_MUL_RUN) && (cnt == LAST);
   assign product = acc_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_MUL_RUN;
                  cnt   <= '0;
               end
            end
            ST_MUL_RUN: begin
               if (cnt == LAST) state <= ST_IDLE;
               else             cnt   <= cnt + 1'b1;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Datapath: operands load on accept, then shift one bit per iteration
   always_ff @(posedge clk) begin
      if (state == ST_IDLE && start) begin
         mcand_p0  <= {{WIDTH{1'b0}}, op_a};
         mplier_p0 <= op_b;
         acc_p0    <= '0;
      end else if (state == ST_MUL_RUN) begin
         mcand_p0  <= mcand_p0 << 1;
         mplier_p0 <= mplier_p0 >> 1;
         acc_p0    <= acc_nxt;
      end
   end

endmodule

// File: rtl/alu_unit.sv
// ALU: single-cycle ADD/SUB/AND/OR, multi-cycle MUL via alu_mul_seq; registered result with zero/overflow flags.
module alu_unit
   import alu_defs::*;
#(
   parameter int WIDTH      = 32,
   parameter int MUL_CYCLES = WIDTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [3:0]        ctrl_command,
   input  logic [WIDTH-1:0]  op_a,
   input  logic [WIDTH-1:0]  op_b,
   output logic              busy,
   output logic              done,
   output logic [WIDTH-1:0]  result,
   output logic              zero,
   output logic              overflow
);

   logic                accept;
   logic                is_mul;
   logic                mul_done;
   logic [2*WIDTH-1:0]  mul_prod;
   logic [WIDTH-1:0]    alu_res;
   logic                alu_ovf;

   function automatic logic add_ovf(input logic [WIDTH-1:0] a, b, s);
      return (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
   endfunction

   function automatic logic sub_ovf(input logic [WIDTH-1:0] a, b, d);
      return (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
   endfunction

   assign is_mul = (ctrl_command == OP_MUL);
   assign accept = start && !busy;

   alu_mul_seq #(
      .WIDTH      (WIDTH),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (accept && is_mul),
      .op_a    (op_a),
      .op_b    (op_b),
      .busy    (busy),
      .done    (mul_done),
      .product (mul_prod)
   );

   // Unused opcodes fall through to ADD
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (ctrl_command)
         OP_SUB: begin
            alu_res = op_a - op_b;
            alu_ovf = sub_ovf(op_a, op_b, alu_res);
         end
         OP_AND: alu_res = op_a & op_b;
         OP_OR:  alu_res = op_a | op_b;
         default: begin
            alu_res = op_a + op_b;
            alu_ovf = add_ovf(op_a, op_b, alu_res);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done     <= 1'b0;
         result   <= '0;
         zero     <= 1'b1;
         overflow <= 1'b0;
      end else begin
         done <= 1'b0;
         if (mul_done) begin
            result   <= mul_prod[WIDTH-1:0];
            zero     <= (mul_prod[WIDTH-1:0] == '0);
            overflow <= |mul_prod[2*WIDTH-1:WIDTH];
            done     <= 1'b1;
         end else if (accept && !is_mul) begin
            result   <= alu_res;
            zero     <= (alu_res == '0);
            overflow <= alu_ovf;
            done     <= 1'b1;
         end
      end
   end

endmodule
